// File: rtl/hdlc_host_ctrl_if.sv
// Bundle of the HDLC core register bus, the outbound/inbound byte streams and
// the event pulses exchanged between the host controller and its environment.
interface hdlc_host_ctrl_if;
  logic [2:0] address;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       tx_done;
  logic       rx_ready;
  logic       txreq_valid;
  logic [7:0] txreq_data;
  logic       txreq_last;
  logic       txreq_ready;
  logic       tx_abort;
  logic       rxout_valid;
  logic [7:0] rxout_data;
  logic       rxout_last;
  logic       rxout_ready;
  logic       tx_frame_done;
  logic       tx_aborted;
  logic       tx_overlen;
  logic       rx_frame_err;

  modport master (
    output address, write_enable, read_enable, data_in, txreq_ready,
           rxout_valid, rxout_data, rxout_last,
           tx_frame_done, tx_aborted, tx_overlen, rx_frame_err,
    input  data_out, tx_done, rx_ready, txreq_valid, txreq_data, txreq_last,
           tx_abort, rxout_ready
  );

  modport slave (
    input  address, write_enable, read_enable, data_in, txreq_ready,
           rxout_valid, rxout_data, rxout_last,
           tx_frame_done, tx_aborted, tx_overlen, rx_frame_err,
    output data_out, tx_done, rx_ready, txreq_valid, txreq_data, txreq_last,
           tx_abort, rxout_ready
  );
endinterface

// File: rtl/hdlc_host_ctrl.sv
// Host-side sequencer for the HDLC core register bus: loads and launches TX frames
// and drains received frames, letting RX service interleave while TX is on the line.
module hdlc_host_ctrl #(
  parameter int MAX_TX_BYTES = 126
) (
  input  logic             i_clk,
  input  logic             i_rst,
  hdlc_host_ctrl_if.master bus
);
  localparam logic [2:0] A_TX_SC = 3'd0, A_TX_BUFF = 3'd1, A_RX_SC = 3'd2,
                         A_RX_BUFF = 3'd3, A_RX_LEN = 3'd4;
  localparam logic [7:0] C_TX_ENABLE = 8'h02, C_TX_ABORT = 8'h04, C_RX_DROP = 8'h02;
  localparam logic [7:0] C_LAST_IDX = 8'(MAX_TX_BYTES - 1);

  localparam logic [3:0] S_IDLE = 4'd0, S_TX_WR = 4'd1, S_TX_FLUSH = 4'd2,
                         S_TX_GO = 4'd3, S_TX_WAIT = 4'd4, S_TX_ABT = 4'd5,
                         S_RX_SC = 4'd6, S_RX_LEN = 4'd7, S_RX_RD = 4'd8,
                         S_RX_OUT = 4'd9, S_RX_DROP = 4'd10;

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic [3:0] w_ret_state;
  logic       r_phase;
  logic       r_tx_pending;
  logic       r_abort_latched;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_remaining;
  logic [7:0] r_rx_data;
  logic       w_tx_done_seen;
  logic       w_overlen;
  logic       w_status_err;
  logic       w_out_hs;
  logic       w_tx_owned;

  assign w_ret_state    = r_tx_pending ? S_TX_WAIT : S_IDLE;
  assign w_tx_done_seen = (r_state == S_TX_WAIT) && !r_abort_latched && bus.tx_done;
  assign w_overlen      = (r_state == S_TX_WR) && bus.txreq_valid && !bus.txreq_last &&
                          (r_byte_cnt == C_LAST_IDX);
  assign w_status_err   = |bus.data_out[4:2];
  assign w_out_hs       = (r_state == S_RX_OUT) && bus.rxout_ready;
  assign w_tx_owned     = r_tx_pending || (r_state inside {S_TX_WR, S_TX_FLUSH, S_TX_GO});

  // Header reads use r_phase: 0 issues the read, 1 consumes DataOut.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_ready)         w_state_next = S_RX_SC;
        else if (bus.txreq_valid) w_state_next = S_TX_WR;
      end
      S_TX_WR: begin
        if (bus.txreq_valid && bus.txreq_last) w_state_next = S_TX_GO;
        else if (w_overlen)                    w_state_next = S_TX_FLUSH;
      end
      S_TX_FLUSH: if (bus.txreq_valid && bus.txreq_last) w_state_next = S_TX_GO;
      S_TX_GO:    w_state_next = S_TX_WAIT;
      S_TX_WAIT: begin
        if (r_abort_latched)   w_state_next = S_TX_ABT;
        else if (bus.tx_done)  w_state_next = S_IDLE;
        else if (bus.rx_ready) w_state_next = S_RX_SC;
      end
      S_TX_ABT:  w_state_next = S_IDLE;
      S_RX_SC:   if (r_phase) w_state_next = w_status_err ? S_RX_DROP : S_RX_LEN;
      S_RX_LEN:  if (r_phase) w_state_next = (bus.data_out == 8'd0) ? S_RX_DROP : S_RX_RD;
      S_RX_RD:   w_state_next = S_RX_OUT;
      S_RX_OUT:  if (w_out_hs) w_state_next = (r_remaining == 8'd1) ? w_ret_state : S_RX_RD;
      S_RX_DROP: w_state_next = w_ret_state;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.address       = A_TX_SC;
    bus.write_enable  = 1'b0;
    bus.read_enable   = 1'b0;
    bus.data_in       = 8'd0;
    bus.txreq_ready   = 1'b0;
    bus.rxout_valid   = 1'b0;
    bus.rxout_data    = 8'd0;
    bus.rxout_last    = 1'b0;
    bus.tx_frame_done = 1'b0;
    bus.tx_aborted    = 1'b0;
    bus.tx_overlen    = 1'b0;
    bus.rx_frame_err  = 1'b0;
    case (r_state)
      S_TX_WR: begin
        bus.address      = A_TX_BUFF;
        bus.txreq_ready  = 1'b1;
        bus.write_enable = bus.txreq_valid;
        bus.data_in      = bus.txreq_valid ? bus.txreq_data : 8'd0;
        bus.tx_overlen   = w_overlen;
      end
      S_TX_FLUSH: bus.txreq_ready = 1'b1;
      S_TX_GO: begin
        bus.write_enable = 1'b1;
        bus.data_in      = C_TX_ENABLE;
      end
      S_TX_WAIT: bus.tx_frame_done = w_tx_done_seen;
      S_TX_ABT: begin
        bus.write_enable = 1'b1;
        bus.data_in      = C_TX_ABORT;
        bus.tx_aborted   = 1'b1;
      end
      S_RX_SC: begin
        bus.address      = A_RX_SC;
        bus.read_enable  = !r_phase;
        bus.rx_frame_err = r_phase && w_status_err;
      end
      S_RX_LEN: begin
        bus.address     = A_RX_LEN;
        bus.read_enable = !r_phase;
      end
      S_RX_RD: begin
        bus.address     = A_RX_BUFF;
        bus.read_enable = 1'b1;
      end
      S_RX_OUT: begin
        bus.address     = A_RX_BUFF;
        bus.rxout_valid = 1'b1;
        // First cycle forwards DataOut directly so a byte costs only two cycles.
        bus.rxout_data  = r_phase ? bus.data_out : r_rx_data;
        bus.rxout_last  = (r_remaining == 8'd1);
      end
      S_RX_DROP: begin
        bus.address      = A_RX_SC;
        bus.write_enable = 1'b1;
        bus.data_in      = C_RX_DROP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_phase         <= 1'b0;
      r_tx_pending    <= 1'b0;
      r_abort_latched <= 1'b0;
      r_byte_cnt      <= 8'd0;
      r_remaining     <= 8'd0;
      r_rx_data       <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_phase <= (w_state_next != r_state) ? (w_state_next == S_RX_OUT)
                                           : (r_state inside {S_RX_SC, S_RX_LEN});

      if (r_state == S_TX_GO)
        r_tx_pending <= 1'b1;
      else if (r_state == S_TX_ABT || w_tx_done_seen)
        r_tx_pending <= 1'b0;

      // A completed frame also retires an abort that arrived in the same cycle.
      if (r_state == S_TX_ABT || w_tx_done_seen)
        r_abort_latched <= 1'b0;
      else if (bus.tx_abort && w_tx_owned)
        r_abort_latched <= 1'b1;

      if (r_state == S_IDLE)
        r_byte_cnt <= 8'd0;
      else if (r_state == S_TX_WR && bus.txreq_valid)
        r_byte_cnt <= r_byte_cnt + 8'd1;

      if (r_state == S_RX_LEN && r_phase)
        r_remaining <= bus.data_out;
      else if (w_out_hs)
        r_remaining <= r_remaining - 8'd1;

      if (r_state == S_RX_OUT && r_phase)
        r_rx_data <= bus.data_out;
    end
  end
endmodule

// File: tb/tb_hdlc_host_ctrl.sv
// Directed bench for hdlc_host_ctrl: a small core model answers register reads,
// a bus monitor logs accesses/events, and the main sequence checks them.
module tb_hdlc_host_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdlc_host_ctrl_if bus_if();
  hdlc_host_ctrl #(.MAX_TX_BYTES(126)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  wire [27:0] w_outs = {bus_if.address, bus_if.write_enable, bus_if.read_enable,
                        bus_if.data_in, bus_if.txreq_ready, bus_if.rxout_valid,
                        bus_if.rxout_data, bus_if.rxout_last, bus_if.tx_frame_done,
                        bus_if.tx_aborted, bus_if.tx_overlen, bus_if.rx_frame_err};

  // Core register model for reads
  logic [7:0] rx_sc_val;
  logic [7:0] rx_len_val;
  logic [7:0] rx_mem [0:255];
  int         rx_ptr = 0;
  always @(posedge clk) begin
    if (bus_if.read_enable) begin
      case (bus_if.address)
        3'd2:    bus_if.data_out <= rx_sc_val;
        3'd4:    bus_if.data_out <= rx_len_val;
        3'd3: begin
          bus_if.data_out <= rx_mem[rx_ptr[7:0]];
          rx_ptr <= rx_ptr + 1;
        end
        default: bus_if.data_out <= 8'h00;
      endcase
    end
  end

  // Bus monitor
  int         cyc = 0;
  int         last_rd = -10;
  int         n_viol = 0;
  int         n_done = 0, n_abt = 0, n_ovl = 0, n_ferr = 0, n_valid = 0;
  logic [2:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  logic [2:0] rd_addr_q[$];
  logic [7:0] rx_data_q[$];
  logic       rx_last_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus_if.write_enable) begin
        wr_addr_q.push_back(bus_if.address);
        wr_data_q.push_back(bus_if.data_in);
        wr_cyc_q.push_back(cyc);
      end
      if (bus_if.read_enable) begin
        rd_addr_q.push_back(bus_if.address);
        last_rd <= cyc;
      end
      if ((bus_if.write_enable && bus_if.read_enable) ||
          ((bus_if.write_enable || bus_if.read_enable) && cyc == last_rd + 1))
        n_viol <= n_viol + 1;
      if (bus_if.rxout_valid && bus_if.rxout_ready) begin
        rx_data_q.push_back(bus_if.rxout_data);
        rx_last_q.push_back(bus_if.rxout_last);
      end
      if (bus_if.rxout_valid)   n_valid <= n_valid + 1;
      if (bus_if.tx_frame_done) n_done  <= n_done + 1;
      if (bus_if.tx_aborted)    n_abt   <= n_abt + 1;
      if (bus_if.tx_overlen)    n_ovl   <= n_ovl + 1;
      if (bus_if.rx_frame_err)  n_ferr  <= n_ferr + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] tx_buf [0:255];

  task automatic send_bytes(input int n);
    int   i = 0;
    int   guard = 0;
    logic hs;
    bus_if.txreq_valid = 1'b1;
    bus_if.txreq_data  = tx_buf[0];
    bus_if.txreq_last  = (n == 1);
    while (i < n && guard < 2000) begin
      hs = bus_if.txreq_ready;
      tick();
      guard++;
      if (hs) begin
        i++;
        if (i < n) begin
          bus_if.txreq_data = tx_buf[i];
          bus_if.txreq_last = (i == n - 1);
        end
      end
    end
    bus_if.txreq_valid = 1'b0;
    bus_if.txreq_last  = 1'b0;
    check("tx_bytes_accepted", i, n);
  endtask

  task automatic pulse_rx_ready();
    bus_if.rx_ready = 1'b1;
    tick();
    bus_if.rx_ready = 1'b0;
  endtask

  task automatic wait_rx_bytes(input int qb, input int n, input logic toggle);
    int guard = 0;
    while ((rx_data_q.size() - qb) < n && guard < 80) begin
      if (toggle) bus_if.rxout_ready = ~bus_if.rxout_ready;
      tick();
      guard++;
    end
    bus_if.rxout_ready = 1'b0;
    check("rx_byte_count", rx_data_q.size() - qb, n);
  endtask

  initial begin
    int wb, rb, qb, d0, ab, ov, fe, vb, errs, guard;
    logic [7:0] exp_b;
    bus_if.tx_done     = 1'b1;
    bus_if.rx_ready    = 1'b0;
    bus_if.txreq_valid = 1'b0;
    bus_if.txreq_data  = 8'h00;
    bus_if.txreq_last  = 1'b0;
    bus_if.tx_abort    = 1'b0;
    bus_if.rxout_ready = 1'b0;
    rx_sc_val  = 8'h00;
    rx_len_val = 8'h00;
    for (int k = 0; k < 256; k++) rx_mem[k] = 8'h00;

    // Reset values
    tick(2);
    check("reset_outputs", 32'(w_outs), 32'h0);
    rst = 1'b0;
    tick(2);
    check("idle_outputs", 32'(w_outs), 32'h0);

    // TX three bytes then Tx_Enable; Tx_Done completes the frame
    wb = wr_addr_q.size();
    d0 = n_done;
    tx_buf[0] = 8'hA1; tx_buf[1] = 8'hB2; tx_buf[2] = 8'hC3;
    bus_if.tx_done = 1'b0;
    send_bytes(3);
    tick(2);
    check("tx3_write_count", wr_addr_q.size() - wb, 4);
    check("tx3_wr0", 32'({wr_addr_q[wb],   wr_data_q[wb]}),   32'({3'd1, 8'hA1}));
    check("tx3_wr1", 32'({wr_addr_q[wb+1], wr_data_q[wb+1]}), 32'({3'd1, 8'hB2}));
    check("tx3_wr2", 32'({wr_addr_q[wb+2], wr_data_q[wb+2]}), 32'({3'd1, 8'hC3}));
    check("tx3_go",  32'({wr_addr_q[wb+3], wr_data_q[wb+3]}), 32'({3'd0, 8'h02}));
    check("tx3_consecutive", wr_cyc_q[wb+3] - wr_cyc_q[wb], 3);
    check("tx3_no_early_done", n_done - d0, 0);
    bus_if.tx_done = 1'b1;
    #1;
    check("tx3_done_same_cycle", 32'(bus_if.tx_frame_done), 1);
    tick(3);
    check("tx3_done_once", n_done - d0, 1);

    // Clean RX frame with consumer toggling Ready
    rx_sc_val = 8'h01; rx_len_val = 8'h04;
    rx_mem[(rx_ptr+0) % 256] = 8'h11; rx_mem[(rx_ptr+1) % 256] = 8'h22;
    rx_mem[(rx_ptr+2) % 256] = 8'h33; rx_mem[(rx_ptr+3) % 256] = 8'h44;
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); qb = rx_data_q.size();
    pulse_rx_ready();
    wait_rx_bytes(qb, 4, 1'b1);
    tick(2);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      exp_b = 8'h11 * 8'(k + 1);
      if (rx_data_q.size() > qb + k) begin
        if (rx_data_q[qb+k] !== exp_b || rx_last_q[qb+k] !== (k == 3)) errs++;
      end else errs++;
    end
    check("rx_clean_bytes_errs", errs, 0);
    check("rx_clean_read_count", rd_addr_q.size() - rb, 6);
    check("rx_clean_read_hdr", 32'({rd_addr_q[rb], rd_addr_q[rb+1]}), 32'({3'd2, 3'd4}));
    check("rx_clean_read_body", 32'({rd_addr_q[rb+2], rd_addr_q[rb+3], rd_addr_q[rb+4],
                                     rd_addr_q[rb+5]}), 32'(12'o3333));
    check("rx_clean_no_write", wr_addr_q.size() - wb, 0);

    // RX with FrameError status: dropped, error pulse, nothing emitted
    rx_sc_val = 8'h05;
    wb = wr_addr_q.size(); rb = rd_addr_q.size(); fe = n_ferr; vb = n_valid;
    pulse_rx_ready();
    tick(8);
    check("rx_err_pulse", n_ferr - fe, 1);
    check("rx_err_write_count", wr_addr_q.size() - wb, 1);
    check("rx_err_drop_write", 32'({wr_addr_q[wb], wr_data_q[wb]}), 32'({3'd2, 8'h02}));
    check("rx_err_read_count", rd_addr_q.size() - rb, 1);
    check("rx_err_no_valid", n_valid - vb, 0);

    // Over-length TX: 126 bytes written, the rest flushed, frame still launched
    for (int k = 0; k < 130; k++) tx_buf[k] = 8'(k);
    wb = wr_addr_q.size(); ov = n_ovl; d0 = n_done;
    bus_if.tx_done = 1'b0;
    send_bytes(130);
    tick(2);
    check("ovl_pulse", n_ovl - ov, 1);
    check("ovl_write_count", wr_addr_q.size() - wb, 127);
    errs = 0;
    for (int k = 0; k < 126; k++)
      if (wr_addr_q.size() > wb + k)
        if (wr_addr_q[wb+k] !== 3'd1 || wr_data_q[wb+k] !== 8'(k)) errs++;
    check("ovl_payload_errs", errs, 0);
    if (wr_addr_q.size() >= wb + 127)
      check("ovl_go", 32'({wr_addr_q[wb+126], wr_data_q[wb+126]}), 32'({3'd0, 8'h02}));
    bus_if.tx_done = 1'b1;
    tick(2);
    check("ovl_done", n_done - d0, 1);

    // TX waiting; RX frame serviced in between, then abort
    tx_buf[0] = 8'h10; tx_buf[1] = 8'h20;
    wb = wr_addr_q.size(); ab = n_abt; d0 = n_done;
    bus_if.tx_done = 1'b0;
    send_bytes(2);
    tick(2);
    rx_sc_val = 8'h00; rx_len_val = 8'h02;
    rx_mem[(rx_ptr+0) % 256] = 8'h5A; rx_mem[(rx_ptr+1) % 256] = 8'hA5;
    qb = rx_data_q.size();
    bus_if.rxout_ready = 1'b1;
    pulse_rx_ready();
    wait_rx_bytes(qb, 2, 1'b0);
    tick(3);
    if (rx_data_q.size() >= qb + 2) begin
      check("intl_rx_b0", 32'({rx_last_q[qb],   rx_data_q[qb]}),   32'({1'b0, 8'h5A}));
      check("intl_rx_b1", 32'({rx_last_q[qb+1], rx_data_q[qb+1]}), 32'({1'b1, 8'hA5}));
    end
    bus_if.tx_abort = 1'b1;
    tick();
    bus_if.tx_abort = 1'b0;
    tick(3);
    check("abort_write_count", wr_addr_q.size() - wb, 4);
    if (wr_addr_q.size() >= wb + 4)
      check("abort_write", 32'({wr_addr_q[wb+3], wr_data_q[wb+3]}), 32'({3'd0, 8'h04}));
    check("abort_pulse", n_abt - ab, 1);
    bus_if.tx_done = 1'b1;
    tick(2);
    check("abort_no_done", n_done - d0, 0);

    // Simultaneous RX and TX request: RX first; reset in the middle of RX_OUT
    rx_sc_val = 8'h00; rx_len_val = 8'h03;
    rx_mem[(rx_ptr+0) % 256] = 8'h01; rx_mem[(rx_ptr+1) % 256] = 8'h02;
    rx_mem[(rx_ptr+2) % 256] = 8'h03;
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    bus_if.rxout_ready = 1'b0;
    bus_if.txreq_valid = 1'b1;
    bus_if.txreq_data  = 8'h77;
    bus_if.txreq_last  = 1'b1;
    pulse_rx_ready();
    guard = 0;
    while (!bus_if.rxout_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("simul_rxout_valid", 32'(bus_if.rxout_valid), 1);
    check("simul_rx_first_read", 32'(rd_addr_q.size() > rb ? rd_addr_q[rb] : 3'd7), 32'(3'd2));
    check("simul_no_tx_write", wr_addr_q.size() - wb, 0);
    rst = 1'b1;
    bus_if.txreq_valid = 1'b0;
    bus_if.txreq_last  = 1'b0;
    #1;
    check("reset_mid_rxout", 32'(w_outs), 32'h0);
    tick();
    check("reset_mid_rxout_edge", 32'(w_outs), 32'h0);
    rst = 1'b0;
    tick(2);
    check("post_reset_idle", 32'(w_outs), 32'h0);

    check("bus_protocol_violations", n_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hdlc_host_ctrl.md
# hdlc_host_ctrl

Host-side sequencer that owns the HDLC core's 8-bit register bus (Address/WriteEnable/ReadEnable/DataIn/DataOut). It accepts outbound frames from a byte-stream requester, loads and launches them through the core, and drains received frames out of the core onto a byte-stream consumer. It arbitrates single-port register access between the TX job and RX service, with RX service allowed to interleave while a TX frame is on the line.

## Interface
- MAX_TX_BYTES, 126, maximum payload bytes loaded per TX frame (core buffer is 128 incl. FCS)
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- Address  out  3  core register address: 0 Tx_SC, 1 Tx_Buff, 2 Rx_SC, 3 Rx_Buff, 4 Rx_Len
- WriteEnable  out  1  core write strobe, one cycle per access
- ReadEnable  out  1  core read strobe, one cycle per access
- DataIn  out  8  write data to core
- DataOut  in  8  core read data, valid the cycle after ReadEnable
- Tx_Done  in  1  core TX idle/buffer empty; core drops it once its buffer holds data
- Rx_Ready  in  1  core holds a complete received frame
- TxReq_Valid / TxReq_Data[7:0] / TxReq_Last  in  1/8/1  outbound byte stream
- TxReq_Ready  out  1  byte accepted when Valid&Ready
- TxAbort  in  1  request abort of current TX frame
- RxOut_Valid / RxOut_Data[7:0] / RxOut_Last  out  1/8/1  received byte stream
- RxOut_Ready  in  1  consumer accepts byte
- TxFrameDone, TxAborted, TxOverlen, RxFrameErr  out  1 each  single-cycle event pulses

## Operation
- Reset: all outputs 0, Address=0, state IDLE, flags tx_pending/abort_latched cleared.
- States: IDLE, TX_WR, TX_FLUSH, TX_GO, TX_WAIT, TX_ABT, RX_SC, RX_LEN, RX_RD, RX_OUT, RX_DROP.
- IDLE: Rx_Ready=1 -> RX_SC (RX wins simultaneous request); else TxReq_Valid=1 -> TX_WR.
- TX_WR: TxReq_Ready=1; each accepted byte -> write Address=1, DataIn=byte same cycle; byte counter +1. On Last -> TX_GO. On counter reaching MAX_TX_BYTES without Last -> pulse TxOverlen, -> TX_FLUSH. TX_WR is never preempted.
- TX_FLUSH: TxReq_Ready=1, bytes discarded until Last accepted, then TX_GO (truncated frame is sent).
- TX_GO: write Address=0, DataIn=0x02 (Tx_Enable); set tx_pending; -> TX_WAIT.
- TX_WAIT: priority abort_latched -> TX_ABT; else Tx_Done=1 -> pulse TxFrameDone, clear tx_pending, -> IDLE; else Rx_Ready=1 -> RX_SC.
- TX_ABT: write Address=0, DataIn=0x04 (Tx_AbortFrame); pulse TxAborted; clear tx_pending, abort_latched; -> IDLE.
- TxAbort latched (abort_latched) whenever tx_pending or state in TX_WR/TX_FLUSH/TX_GO; ignored in IDLE. Acted on only in TX_WAIT.
- RX_SC: read Address=2; status captured next cycle. Any of bits 2 (FrameError), 3 (AbortSignal), 4 (Overflow) set -> pulse RxFrameErr, -> RX_DROP; else -> RX_LEN.
- RX_LEN: read Address=4 -> N. N=0 -> RX_DROP (no RxFrameErr); else RX_RD with remaining=N.
- RX_RD: read Address=3, capture next cycle into RxOut_Data, -> RX_OUT.
- RX_OUT: RxOut_Valid=1, RxOut_Last=(remaining==1), data stable until Ready. On handshake remaining-1; 0 -> return state, else RX_RD.
- RX_DROP: write Address=2, DataIn=0x02 (Rx_Drop); -> return state.
- Return state after RX: TX_WAIT if tx_pending else IDLE.
- Counters 8-bit; N used as read unsigned, no saturation needed (core max 128).

## Timing
- At most one of WriteEnable/ReadEnable high per cycle; each strobe exactly one cycle, Address/DataIn valid same cycle.
- Read issue at cycle t, DataOut sampled at t+1; next access no earlier than t+2.
- TX load: one byte/cycle when TxReq_Valid held high; TX_GO write occurs the cycle after Last accepted.
- RX: min 2 cycles/byte plus consumer backpressure; header overhead 4 cycles (2 reads).
- TxFrameDone asserted the cycle Tx_Done=1 is seen in TX_WAIT.
- Rst mid-frame: immediate return to reset values; no cleanup bus writes issued; core reset separately.
- Rx_Ready remaining high after drain/drop is treated as a new frame only on the next IDLE/TX_WAIT evaluation.

## Test plan
- TX 3 bytes 0xA1,0xB2,0xC3 (Last on third) -> writes addr1 x3 in consecutive cycles, then addr0=0x02; Tx_Done rises -> TxFrameDone pulse once.
- RX clean frame, Rx_SC=0x01, Rx_Len=4 -> reads addr2, addr4, 4x addr3; RxOut emits 4 bytes, Last on 4th; with Ready toggling every other cycle no byte lost/duplicated.
- RX with Rx_SC=0x05 -> RxFrameErr pulse, write addr2=0x02, no RxOut_Valid.
- TX of 130 bytes without early Last (MAX_TX_BYTES=126) -> 126 writes, TxOverlen pulse, 4 bytes discarded, then addr0=0x02.
- TX in TX_WAIT with Rx_Ready rising -> RX frame drained, returns to TX_WAIT; TxAbort then -> addr0=0x04, TxAborted, no TxFrameDone.
- Rx_Ready and TxReq_Valid asserted same cycle in IDLE -> RX serviced first; Rst asserted mid RX_OUT -> all outputs 0 next edge.
